conv_tensor_engine: RTL and testbench

//  Parametrised sequential KxK convolution engine (stage-2 successor). One MAC per clock.

---
 rtl/conv_tensor_engine.sv | 218 +++++++++++++++++++++
 tb/tb_conv_tensor_engine.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_tensor_engine.sv
// conv_tensor_engine
//   Sequential KxK convolution engine with one multiply-accumulate per clock.
//   For every filter f, output row and output column (f outermost, col
//   innermost) it reads the K*K*CH input taps from a synchronous RAM and
//   accumulates them with the filter weights. It then adds the filter bias,
//   optionally applies ReLU, saturates to OUT_W bits, and presents the result
//   on a valid/ready output port.
//
//   Build option: define CONV_ENGINE_RELU_EN to clamp negative sums to zero
//   before saturation. Without it the result is signed and saturates at both ends.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start               begin a full pass (sampled only while idle)
//   busy                high whenever the engine is not idle
//   done                one-cycle pulse after the last result is accepted
//   in_rd_en, in_addr   tensor RAM read strobe / address ((row+r)*IN_DIM+(col+c))*CH+ch
//   in_data             signed RAM data, valid one cycle after in_rd_en
//   weights             packed w[f][r][c][ch], DW bits each, ch fastest
//   bias                packed b[f], ACC_W bits each
//   out_valid/out_ready result handshake
//   out_data, out_addr  saturated result and its index f*OUT_DIM^2+row*OUT_DIM+col
module conv_tensor_engine #(
  parameter int IN_DIM = 8,
  parameter int CH     = 3,
  parameter int NFILT  = 4,
  parameter int K      = 3,
  parameter int DW     = 17,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 35
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic                                                    start,
  output logic                                                    busy,
  output logic                                                    done,
  output logic                                                    in_rd_en,
  output logic [$clog2(IN_DIM*IN_DIM*CH)-1:0]                     in_addr,
  input  logic signed [DW-1:0]                                    in_data,
  input  logic [NFILT*K*K*CH*DW-1:0]                              weights,
  input  logic [NFILT*ACC_W-1:0]                                  bias,
  output logic                                                    out_valid,
  input  logic                                                    out_ready,
  output logic signed [OUT_W-1:0]                                 out_data,
  output logic [$clog2(NFILT*(IN_DIM-K+1)*(IN_DIM-K+1))-1:0]      out_addr
);

  localparam int OUT_DIM = IN_DIM - K + 1;
  localparam int TAPS    = K * K * CH;
  localparam int T       = TAPS + 1;
  localparam int AW      = $clog2(IN_DIM * IN_DIM * CH);
  localparam int OAW     = $clog2(NFILT * OUT_DIM * OUT_DIM);
  localparam int TW      = $clog2(T + 1);
  localparam int KW      = (K > 1) ? $clog2(K) : 1;
  localparam int CW      = (CH > 1) ? $clog2(CH) : 1;
  localparam int PW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int FW      = (NFILT > 1) ? $clog2(NFILT) : 1;
  localparam int WBW     = $clog2(NFILT * TAPS * DW);
  localparam int BBW     = $clog2(NFILT * ACC_W);

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_BIAS, S_OUT, S_DONE} state_t;

  state_t r_state, w_next;

  logic [TW-1:0]            r_tap;
  logic [KW-1:0]            r_kr, r_kc;
  logic [CW-1:0]            r_kch;
  logic [PW-1:0]            r_row, r_col;
  logic [FW-1:0]            r_f;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_out_valid;
  logic signed [OUT_W-1:0]  r_out_data;
  logic [OAW-1:0]           r_out_addr;

  logic                     w_last;
  logic                     w_enter_mac;
  logic [WBW-1:0]           w_wbase;
  logic [BBW-1:0]           w_bbase;
  logic signed [DW-1:0]     w_wt;
  logic signed [2*DW-1:0]   w_prod;
  logic signed [ACC_W-1:0]  w_bias_f;
  logic signed [ACC_W:0]    w_sum;
  logic signed [ACC_W:0]    w_rel;
  logic [ACC_W-OUT_W+1:0]   w_top;
  logic signed [OUT_W-1:0]  w_sat;
  logic [OAW-1:0]           w_oaddr;

  assign w_last = (r_f == FW'(NFILT - 1)) && (r_row == PW'(OUT_DIM - 1)) &&
                  (r_col == PW'(OUT_DIM - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and control outputs
  always_comb begin
    w_next   = r_state;
    busy     = (r_state != S_IDLE);
    done     = 1'b0;
    in_rd_en = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_MAC;
      S_MAC: begin
        in_rd_en = (r_tap != TW'(T - 1));
        if (r_tap == TW'(T - 1)) w_next = S_BIAS;
      end
      S_BIAS: w_next = S_OUT;
      S_OUT:  if (out_ready) w_next = w_last ? S_DONE : S_MAC;
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_enter_mac = (w_next == S_MAC) && (r_state != S_MAC);

  assign in_addr = in_rd_en ?
    AW'(((int'(r_row) + int'(r_kr)) * IN_DIM + int'(r_col) + int'(r_kc)) * CH + int'(r_kch)) :
    '0;

  // Data arriving in MAC cycle i belongs to tap i-1, so the weight lags the address by one.
  assign w_wbase  = (r_tap == '0) ? '0 : WBW'((int'(r_f) * TAPS + int'(r_tap) - 1) * DW);
  assign w_wt     = weights[w_wbase +: DW];
  assign w_prod   = in_data * w_wt;

  assign w_bbase  = BBW'(int'(r_f) * ACC_W);
  assign w_bias_f = bias[w_bbase +: ACC_W];
  assign w_sum    = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_bias_f);

`ifdef CONV_ENGINE_RELU_EN
  assign w_rel = w_sum[ACC_W] ? '0 : w_sum;
`else
  assign w_rel = w_sum;
`endif

  // The value fits in OUT_W bits when every bit from OUT_W-1 upward equals the sign.
  assign w_top = w_rel[ACC_W:OUT_W-1];
  assign w_sat = ((&w_top) || !(|w_top)) ? w_rel[OUT_W-1:0] :
                 (w_rel[ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}});

  assign w_oaddr = OAW'(int'(r_f) * OUT_DIM * OUT_DIM + int'(r_row) * OUT_DIM + int'(r_col));

  // Datapath: tap/kernel counters, accumulator, output position and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tap       <= '0;
      r_kr        <= '0;
      r_kc        <= '0;
      r_kch       <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_f         <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
    end else begin
      if (w_enter_mac) begin
        r_tap <= '0;
        r_kr  <= '0;
        r_kc  <= '0;
        r_kch <= '0;
        r_acc <= '0;
      end else if (r_state == S_MAC) begin
        if (r_tap != '0) r_acc <= r_acc + ACC_W'(w_prod);
        r_tap <= r_tap + TW'(1);
        if (in_rd_en) begin
          if (r_kch == CW'(CH - 1)) begin
            r_kch <= '0;
            if (r_kc == KW'(K - 1)) begin
              r_kc <= '0;
              r_kr <= r_kr + KW'(1);
            end else begin
              r_kc <= r_kc + KW'(1);
            end
          end else begin
            r_kch <= r_kch + CW'(1);
          end
        end
      end

      if (r_state == S_IDLE && start) begin
        r_f   <= '0;
        r_row <= '0;
        r_col <= '0;
      end else if (r_state == S_OUT && out_ready && !w_last) begin
        if (r_col == PW'(OUT_DIM - 1)) begin
          r_col <= '0;
          if (r_row == PW'(OUT_DIM - 1)) begin
            r_row <= '0;
            r_f   <= r_f + FW'(1);
          end else begin
            r_row <= r_row + PW'(1);
          end
        end else begin
          r_col <= r_col + PW'(1);
        end
      end

      if (r_state == S_BIAS) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sat;
        r_out_addr  <= w_oaddr;
      end else if (r_state == S_OUT && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;

endmodule

// File: tb/tb_conv_tensor_engine.sv
// Bench for conv_tensor_engine: a behavioural convolution model computes each
// expected result from the tensor/weight/bias arrays; a negedge compare process
// checks every accepted result, handshake holding and stall behaviour.
module tb_conv_tensor_engine;

  localparam int IN_DIM  = 8;
  localparam int CH      = 3;
  localparam int NFILT   = 4;
  localparam int K       = 3;
  localparam int DW      = 17;
  localparam int ACC_W   = 40;
  localparam int OUT_W   = 35;
  localparam int OUT_DIM = IN_DIM - K + 1;
  localparam int NOUT    = NFILT * OUT_DIM * OUT_DIM;
  localparam int NIN     = IN_DIM * IN_DIM * CH;
  localparam int AW      = $clog2(NIN);
  localparam int OAW     = $clog2(NOUT);
  localparam int T       = K * K * CH + 1;
  localparam int M_PLAIN = 0, M_FIRST = 1, M_STALL = 2, M_RST = 3, M_BUSY = 4;
  localparam longint SAT_MAX = (longint'(1) << (OUT_W - 1)) - 1;
  localparam longint SAT_MIN = -(longint'(1) << (OUT_W - 1));
`ifdef CONV_ENGINE_RELU_EN
  localparam longint NEG_EXP = 0;
`else
  localparam longint NEG_EXP = -3;
`endif

  logic                           clk, rst, start, busy, done, in_rd_en, out_valid, out_ready;
  logic [AW-1:0]                  in_addr;
  logic signed [DW-1:0]           in_data;
  logic [NFILT*K*K*CH*DW-1:0]     weights;
  logic [NFILT*ACC_W-1:0]         bias;
  logic signed [OUT_W-1:0]        out_data;
  logic [OAW-1:0]                 out_addr;

  int     mem [NIN];
  int     wt  [NFILT][K][K][CH];
  longint bs  [NFILT];
  longint got [NOUT];

  int     n_tests, n_fail;
  int     exp_addr, n_results, n_done;
  longint cyc_cnt, last_acc;
  bit     gap_chk, prev_stall, prev_acc;
  logic signed [OUT_W-1:0] prev_data;
  logic [OAW-1:0]          prev_addr;

  conv_tensor_engine #(
    .IN_DIM(IN_DIM), .CH(CH), .NFILT(NFILT), .K(K), .DW(DW), .ACC_W(ACC_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_rd_en(in_rd_en), .in_addr(in_addr), .in_data(in_data),
    .weights(weights), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr)
  );

  always #5 clk = ~clk;

  // Synchronous tensor RAM; returns junk when not read so stray use of in_data shows up.
  always @(posedge clk) begin
    if (in_rd_en) in_data <= DW'(mem[in_addr]);
    else          in_data <= DW'($urandom);
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Direct convolution of one output position from the stimulus arrays.
  function automatic longint model(input int a);
    int f, row, col;
    longint s;
    f   = a / (OUT_DIM * OUT_DIM);
    row = (a % (OUT_DIM * OUT_DIM)) / OUT_DIM;
    col = a % OUT_DIM;
    s   = bs[f];
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        for (int ch = 0; ch < CH; ch++)
          s += longint'(mem[((row + r) * IN_DIM + (col + c)) * CH + ch]) * longint'(wt[f][r][c][ch]);
`ifdef CONV_ENGINE_RELU_EN
    if (s < 0) s = 0;
`endif
    if (s > SAT_MAX) s = SAT_MAX;
    if (s < SAT_MIN) s = SAT_MIN;
    return s;
  endfunction

  // kind 0: all ones; 1: all ones, bias[2]=-30; 2: all max positive; 3: mixed-sign pattern
  task automatic set_stim(input int kind);
    int vmax;
    vmax = 2 ** (DW - 1) - 1;
    for (int a = 0; a < NIN; a++)
      mem[a] = (kind == 2) ? vmax : (kind == 3) ? ((a * 37) % 201) - 100 : 1;
    for (int f = 0; f < NFILT; f++)
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          for (int ch = 0; ch < CH; ch++) begin
            wt[f][r][c][ch] = (kind == 2) ? vmax :
                              (kind == 3) ? ((f * 7 + r * 5 + c * 3 + ch * 11) % 19) - 9 : 1;
            weights[(((f * K + r) * K + c) * CH + ch) * DW +: DW] = DW'(wt[f][r][c][ch]);
          end
    for (int f = 0; f < NFILT; f++) begin
      bs[f] = (kind == 1 && f == 2) ? -30 : (kind == 3) ? longint'(f * 1000 - 1500) : 0;
      bias[f * ACC_W +: ACC_W] = ACC_W'(bs[f]);
    end
  endtask

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc_cnt++;
    if (rst) begin
      prev_stall = 0;
      prev_acc   = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_addr", out_addr, prev_addr);
      end
      if (prev_acc) chk("valid_drop", out_valid, 0);
      if (out_valid && !out_ready) chk("rd_in_stall", in_rd_en, 0);
      if (out_valid && out_ready) begin
        chk("out_addr", out_addr, exp_addr);
        chk("out_data", out_data, model(exp_addr));
        if (exp_addr < NOUT) got[exp_addr] = out_data;
        if (gap_chk && last_acc >= 0) chk("gap", cyc_cnt - last_acc, T + 2);
        last_acc = cyc_cnt;
        exp_addr++;
        n_results++;
      end
      if (done) n_done++;
      prev_stall = out_valid && !out_ready;
      prev_acc   = out_valid && out_ready;
      prev_data  = out_data;
      prev_addr  = out_addr;
    end
  end

  task automatic run_pass(input int mode);
    int cyc, stallc, d0;
    bit fin, seen, pulsed;
    exp_addr  = 0;
    n_results = 0;
    last_acc  = -1;
    gap_chk   = (mode != M_STALL);
    d0        = n_done;
    out_ready = (mode != M_STALL);
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    chk("busy_after_start", busy, 1);
    cyc = 0; fin = 0; seen = 0; stallc = 0; pulsed = 0;
    while (!fin && cyc < 6000) begin
      @(posedge clk); #1;
      cyc++;
      if (start) start = 0;
      if (!seen && out_valid) begin
        seen = 1;
        if (mode == M_FIRST) chk("latency", cyc, T + 1);
      end
      if (mode == M_STALL && out_valid && !out_ready) begin
        stallc++;
        chk("stall_data", out_data, 27);
        chk("stall_addr", out_addr, 0);
        if (stallc == 10) out_ready = 1;
      end
      if (mode == M_BUSY && !pulsed && n_results == 20) begin
        start  = 1;
        pulsed = 1;
      end
      if (mode == M_RST && n_results == 50) begin
        rst = 1;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_addr", out_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", in_rd_en, 0);
        chk("rst_in_addr", in_addr, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        fin = 1;
      end else if (done) begin
        fin = 1;
        if (mode == M_BUSY) start = 1;
      end
    end
    chk("pass_finished", fin, 1);
    if (mode == M_BUSY) begin
      @(posedge clk); #1 start = 0;
      chk("start_in_done_ignored", busy, 0);
      @(posedge clk); #1;
      chk("still_idle", busy, 0);
    end
    repeat (3) @(posedge clk);
    #1;
    if (mode == M_RST) begin
      chk("no_done_after_rst", n_done - d0, 0);
      chk("results_before_rst", n_results, 50);
      chk("idle_after_rst", busy, 0);
    end else begin
      chk("result_count", n_results, NOUT);
      chk("done_pulses", n_done - d0, 1);
      chk("idle_after_pass", busy, 0);
    end
  endtask

  initial begin
    clk = 0; rst = 1; start = 0; out_ready = 1;
    weights = '0; bias = '0;
    n_tests = 0; n_fail = 0; n_done = 0; n_results = 0; exp_addr = 0;
    cyc_cnt = 0; last_acc = -1; gap_chk = 0;
    set_stim(0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_data", out_data, 0);
    chk("reset_addr", out_addr, 0);
    chk("reset_rd_en", in_rd_en, 0);
    chk("reset_in_addr", in_addr, 0);
    rst = 0;

    chk("model_ones", model(0), 27);
    run_pass(M_FIRST);
    chk("ones_first", got[0], 27);
    chk("ones_last", got[NOUT - 1], 27);

    set_stim(1);
    chk("model_neg_bias", model(72), NEG_EXP);
    run_pass(M_PLAIN);
    chk("bias_addr71", got[71], 27);
    chk("bias_addr72", got[72], NEG_EXP);
    chk("bias_addr107", got[107], NEG_EXP);
    chk("bias_addr108", got[108], 27);

    set_stim(2);
    chk("model_sat", model(0), 64'sd17179869183);
    run_pass(M_PLAIN);
    chk("sat_first", got[0], 64'sd17179869183);
    chk("sat_last", got[NOUT - 1], 64'sd17179869183);

    set_stim(0);
    run_pass(M_STALL);

    set_stim(3);
    run_pass(M_RST);
    run_pass(M_BUSY);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
